dht11_ctrl: RTL

Single-wire bus controller for the DHT11 temperature/humidity sensor. On a `start` request it drives the host start pulse, waits for the sensor response, times 40 data bits, verifies the checksum and presents humidity/temperature bytes with a done/error pulse. It sits between the open-drain sensor pad (external tri-state driven by `dht_oe`) and the system logic that consumes readings.

---
 rtl/dht11_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dht11_ctrl.sv
// -----------------------------------------------------------------------------
// dht11_ctrl
// Single-wire bus controller for the DHT11 temperature/humidity sensor.
// A start request drives the host start pulse, waits for the sensor response,
// times 40 data bits, verifies the checksum and presents the reading together
// with a one-cycle done pulse (err/err_code report the outcome).
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   start     measurement request, accepted only while idle
//   dht_in    raw bus level (asynchronous)
//   dht_oe    1 = pad pulls the bus low, 0 = released (pull-up)
//   busy      transaction in progress (stays high through the done cycle)
//   done      one-cycle end-of-transaction pulse
//   err       transaction failed (valid with done, held until next done)
//   err_code  0 none, 1 no response, 2 bit timeout, 3 checksum
//   hum_int, hum_dec, temp_int, temp_dec   last good reading
// -----------------------------------------------------------------------------
module dht11_ctrl #(
   parameter int CYC_PER_US    = 50,
   parameter int START_US      = 18000,
   parameter int TIMEOUT_US    = 100,
   parameter int BIT_THRESH_US = 40
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dht_in,
   output logic       dht_oe,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   output logic [7:0] hum_int,
   output logic [7:0] hum_dec,
   output logic [7:0] temp_int,
   output logic [7:0] temp_dec
);

   typedef enum logic [3:0] {
      S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
      S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_FAIL
   } state_t;

   localparam int PW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CYC_PER_US - 1);
   // The entry cycle itself is counted, so a phase lasting H us reads H when
   // its terminating edge is detected (both edges see the same sync latency).
   localparam logic [PW-1:0] PRE_ENTRY = (CYC_PER_US > 1) ? PW'(1) : '0;
   localparam logic [14:0]   US_ENTRY  = (CYC_PER_US > 1) ? 15'd0 : 15'd1;
   localparam logic [14:0]   START_C   = 15'(START_US);
   localparam logic [14:0]   TIMEOUT_C = 15'(TIMEOUT_US);
   localparam logic [14:0]   THRESH_C  = 15'(BIT_THRESH_US);

   state_t        state_reg, state_next;
   logic [1:0]    fail_next, fail_code_reg;
   logic          sync1_reg, sync2_reg, s_in_d_reg;
   logic          s_in, rise, fall, timeout, bit_val, sum_ok;
   logic [PW-1:0] pre_reg;
   logic [14:0]   us_cnt_reg;
   logic [39:0]   shift_reg;
   logic [5:0]    bit_idx_reg;
   logic [7:0]    rx_byte [5];
   logic [7:0]    sum;

   assign s_in    = sync2_reg;
   assign rise    = s_in & ~s_in_d_reg;
   assign fall    = ~s_in & s_in_d_reg;
   assign timeout = (us_cnt_reg > TIMEOUT_C);
   assign bit_val = (us_cnt_reg >= THRESH_C);

   // Received bytes, byte 0 being the first one on the wire.
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_byte
         assign rx_byte[gi] = shift_reg[39-8*gi -: 8];
      end
   endgenerate

   assign sum    = rx_byte[0] + rx_byte[1] + rx_byte[2] + rx_byte[3];
   assign sum_ok = (sum == rx_byte[4]);

   assign dht_oe = (state_reg == S_START_LOW);
   // busy covers the done cycle so it falls one cycle after done.
   assign busy   = (state_reg != S_IDLE) | done;

   always_comb begin
      state_next = state_reg;
      fail_next  = 2'd0;
      case (state_reg)
         S_IDLE:      if (start && !done) state_next = S_START_LOW;
         S_START_LOW: if (us_cnt_reg == START_C) state_next = S_RELEASE;
         S_RELEASE: begin
            if (fall) state_next = S_RESP_LOW;
            else if (timeout) begin state_next = S_FAIL; fail_next = 2'd1; end
         end
         S_RESP_LOW: begin
            if (rise) state_next = S_RESP_HIGH;
            else if (timeout) begin state_next = S_FAIL; fail_next = 2'd1; end
         end
         S_RESP_HIGH: begin
            if (fall) state_next = S_BIT_LOW;
            else if (timeout) begin state_next = S_FAIL; fail_next = 2'd1; end
         end
         S_BIT_LOW: begin
            if (rise) state_next = S_BIT_HIGH;
            else if (timeout) begin state_next = S_FAIL; fail_next = 2'd2; end
         end
         S_BIT_HIGH: begin
            if (fall) state_next = (bit_idx_reg == 6'd39) ? S_CHECK : S_BIT_LOW;
            else if (timeout) begin state_next = S_FAIL; fail_next = 2'd2; end
         end
         S_CHECK: begin
            if (sum_ok) state_next = S_IDLE;
            else begin state_next = S_FAIL; fail_next = 2'd3; end
         end
         S_FAIL:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         sync1_reg     <= 1'b0;
         sync2_reg     <= 1'b0;
         s_in_d_reg    <= 1'b0;
         pre_reg       <= '0;
         us_cnt_reg    <= '0;
         shift_reg     <= '0;
         bit_idx_reg   <= '0;
         fail_code_reg <= '0;
         done          <= 1'b0;
         err           <= 1'b0;
         err_code      <= 2'd0;
         hum_int       <= 8'h00;
         hum_dec       <= 8'h00;
         temp_int      <= 8'h00;
         temp_dec      <= 8'h00;
      end else begin
         state_reg  <= state_next;
         sync1_reg  <= dht_in;
         sync2_reg  <= sync1_reg;
         s_in_d_reg <= sync2_reg;

         // Phase timer restarts on every state change.
         if (state_next != state_reg) begin
            pre_reg    <= PRE_ENTRY;
            us_cnt_reg <= US_ENTRY;
         end else if (pre_reg == PRE_LAST) begin
            pre_reg <= '0;
            if (us_cnt_reg != 15'h7fff) us_cnt_reg <= us_cnt_reg + 15'd1;
         end else begin
            pre_reg <= pre_reg + PW'(1);
         end

         if (state_reg == S_RESP_HIGH && fall) bit_idx_reg <= 6'd0;
         if (state_reg == S_BIT_HIGH && fall) begin
            shift_reg   <= {shift_reg[38:0], bit_val};
            bit_idx_reg <= bit_idx_reg + 6'd1;
         end

         if (state_next == S_FAIL) fail_code_reg <= fail_next;

         done <= 1'b0;
         if (state_reg == S_CHECK && sum_ok) begin
            done     <= 1'b1;
            err      <= 1'b0;
            err_code <= 2'd0;
            hum_int  <= rx_byte[0];
            hum_dec  <= rx_byte[1];
            temp_int <= rx_byte[2];
            temp_dec <= rx_byte[3];
         end else if (state_reg == S_FAIL) begin
            done     <= 1'b1;
            err      <= 1'b1;
            err_code <= fail_code_reg;
         end
      end
   end

endmodule
